// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buf
// Purpose  : Parametrised inter-stage pipeline register that carries an
//            opaque payload between two stages with a valid/ready handshake.
//            It can use an optional 2-entry skid buffer, which gives full
//            throughput with a registered in_ready_o. It also provides
//            stall (hold) and flush (bubble) controls, occupancy reporting
//            and a saturating count of entries discarded by flush.
// Ports    : clk, rst (async, active-high)
//            flush_i, stall_i            - pipeline control
//            in_valid_i/in_ready_o/in_data_i    - upstream handshake
//            out_valid_o/out_ready_i/out_data_o - downstream handshake
//            occupancy_o                 - entries held (0..2)
//            drop_cnt_o                  - saturating flushed-entry count
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_buf #(
    parameter int DATA_W        = 256,
    parameter int SKID          = 1,
    parameter int ZERO_ON_FLUSH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o,
    output logic [15:0]       drop_cnt_o
);

    localparam logic [15:0] c_DROP_MAX = 16'hFFFF;

    // Main register M drives the outputs directly; skid register S only
    // holds data when SKID is enabled (it stays constant zero otherwise).
    logic              m_valid_q, m_valid_d;
    logic              s_valid_q, s_valid_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;
    logic [1:0]        occ_q,     occ_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic              w_in_ready;
    logic              w_acc_in;
    logic              w_acc_out;
    logic [16:0]       w_drop_sum;

    generate
        if (SKID != 0) begin : g_ready_skid
            // Registered ready: depends only on skid occupancy, so there is
            // no combinational path from out_ready_i or stall_i.
            assign w_in_ready = ~s_valid_q;
        end else begin : g_ready_comb
            assign w_in_ready = ~m_valid_q | (out_ready_i & ~stall_i);
        end
    endgenerate

    assign w_acc_in  = in_valid_i & w_in_ready;
    assign w_acc_out = m_valid_q & out_ready_i & ~stall_i;

    // Entries lost by a flush: everything held plus anything accepted in the
    // same cycle. The extra bit catches overflow for saturation.
    assign w_drop_sum = {1'b0, drop_cnt_q} + {15'd0, occ_q} + {16'd0, w_acc_in};

    always_comb begin
        m_valid_d  = m_valid_q;
        s_valid_d  = s_valid_q;
        m_data_d   = m_data_q;
        s_data_d   = s_data_q;
        drop_cnt_d = drop_cnt_q;

        if (flush_i) begin
            m_valid_d  = 1'b0;
            s_valid_d  = 1'b0;
            drop_cnt_d = w_drop_sum[16] ? c_DROP_MAX : w_drop_sum[15:0];
            if (ZERO_ON_FLUSH != 0) begin
                m_data_d = '0;
                s_data_d = '0;
            end
        end else if (SKID != 0) begin
            case ({m_valid_q, s_valid_q})
                2'b00: begin
                    if (w_acc_in) begin
                        m_valid_d = 1'b1;
                        m_data_d  = in_data_i;
                    end
                end
                2'b10: begin
                    if (w_acc_in && w_acc_out) begin
                        m_data_d = in_data_i;
                    end else if (w_acc_in) begin
                        s_valid_d = 1'b1;
                        s_data_d  = in_data_i;
                    end else if (w_acc_out) begin
                        m_valid_d = 1'b0;
                    end
                end
                2'b11: begin
                    // Full: in_ready is low, so only the output side moves.
                    if (w_acc_out) begin
                        m_data_d  = s_data_q;
                        s_valid_d = 1'b0;
                    end
                end
                default: begin
                    // S valid without M valid is unreachable; hold.
                end
            endcase
        end else begin
            if (w_acc_in) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data_i;
            end else if (w_acc_out) begin
                m_valid_d = 1'b0;
            end
        end

        occ_d = {1'b0, m_valid_d} + {1'b0, s_valid_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            m_data_q   <= '0;
            s_data_q   <= '0;
            occ_q      <= 2'd0;
            drop_cnt_q <= 16'd0;
        end else begin
            m_valid_q  <= m_valid_d;
            s_valid_q  <= s_valid_d;
            m_data_q   <= m_data_d;
            s_data_q   <= s_data_d;
            occ_q      <= occ_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = m_valid_q;
    assign out_data_o  = m_data_q;
    assign occupancy_o = occ_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule
`default_nettype wire
